// File: rtl/prvp_pulp_clock_divider.sv
// Programmable integer clock divider with glitch-free ratio change on period boundaries.
// Optional PRVP_CLK_DIV_ODD50_EN adds a negedge stage for 50% duty on odd ratios.
module prvp_pulp_clock_divider #(
   parameter int unsigned DIV_W       = 8,
   parameter int unsigned DEFAULT_DIV = 1
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             test_mode_i,
   input  logic [DIV_W-1:0] clk_div_i,
   input  logic             clk_div_valid_i,
   output logic             clk_div_ack_o,
   output logic             clk_o
);

   localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
   localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

   typedef enum logic [1:0] {
      S_BYPASS,
      S_RUN,
      S_PEND
   } state_t;

   state_t           state;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] new_q;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] cnt_next;
   logic [DIV_W-1:0] ratio_next;
   logic             ack;
   logic             clk_div_q;
   logic             clk_div_d;
   logic             clk_run;
   logic             bypass;
   logic             wrap;
   logic             apply;
   logic             take;

   assign bypass     = (div_q <= ONE);
   assign wrap       = !bypass && (cnt == (div_q - ONE));
   assign cnt_next   = (bypass || wrap) ? '0 : cnt + ONE;
   assign apply      = (state == S_PEND) && (bypass || wrap);
   assign take       = clk_div_valid_i && (state != S_PEND) && !ack;
   assign ratio_next = apply ? new_q : div_q;
   // On apply cnt_next is 0, so the new ratio's first high phase starts here
   assign clk_div_d  = (cnt_next < (ratio_next >> 1));

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state     <= (DEF_DIV <= ONE) ? S_BYPASS : S_RUN;
         div_q     <= DEF_DIV;
         new_q     <= DEF_DIV;
         cnt       <= '0;
         ack       <= 1'b0;
         clk_div_q <= 1'b0;
      end else begin
         ack       <= apply;
         cnt       <= cnt_next;
         clk_div_q <= clk_div_d;
         if (apply) begin
            div_q <= new_q;
            state <= (new_q <= ONE) ? S_BYPASS : S_RUN;
         end else if (take) begin
            new_q <= clk_div_i;
            state <= S_PEND;
         end
      end
   end

`ifdef PRVP_CLK_DIV_ODD50_EN
   logic clk_div_n;

   always_ff @(negedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         clk_div_n <= 1'b0;
      end else begin
         clk_div_n <= clk_div_q;
      end
   end

   // Half-cycle stretch of the high phase, only for odd ratios
   assign clk_run = clk_div_q | (div_q[0] & clk_div_n);
`else
   assign clk_run = clk_div_q;
`endif

   assign clk_div_ack_o = ack;
   assign clk_o = rstn_i & ((test_mode_i | bypass) ? clk_i : clk_run);

endmodule

// File: tb/tb_prvp_pulp_clock_divider.sv
// Directed testbench for prvp_pulp_clock_divider.
// Half-cycle samples of clk_o are compared with hand-derived waveforms.
module tb_prvp_pulp_clock_divider;

   logic       clk_i;
   logic       rstn_i;
   logic       test_mode_i;
   logic [7:0] clk_div_i;
   logic       clk_div_valid_i;
   logic       clk_div_ack_o;
   logic       clk_o;

   int checks;
   int failures;

   prvp_pulp_clock_divider #(
      .DIV_W       (8),
      .DEFAULT_DIV (1)
   ) dut (
      .clk_i           (clk_i),
      .rstn_i          (rstn_i),
      .test_mode_i     (test_mode_i),
      .clk_div_i       (clk_div_i),
      .clk_div_valid_i (clk_div_valid_i),
      .clk_div_ack_o   (clk_div_ack_o),
      .clk_o           (clk_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // b[2k] = high half of cycle k, b[2k+1] = low half; call at posedge+1
   task automatic capture(input int n, output logic [63:0] b);
      b = '0;
      #1;
      b[0] = clk_o;
      @(negedge clk_i);
      #2;
      b[1] = clk_o;
      for (int k = 1; k < n; k++) begin
         @(posedge clk_i);
         #2;
         b[2*k] = clk_o;
         @(negedge clk_i);
         #2;
         b[2*k+1] = clk_o;
      end
   endtask

   // Returns at posedge+1 of the edge that raised ack, valid already dropped
   task automatic do_req(input logic [7:0] n, input int lim, output int cyc);
      logic got;
      clk_div_i = n;
      clk_div_valid_i = 1'b1;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < lim) begin
         @(posedge clk_i);
         #1;
         cyc++;
         got = clk_div_ack_o;
      end
      clk_div_valid_i = 1'b0;
      checks++;
      if (got !== 1'b1) begin
         failures++;
         $display("FAIL ack_timeout n=%0d got=%b exp=1 after %0d cycles", n, got, cyc);
      end
   endtask

   task automatic track_check(input string nm, input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk_i);
         #2;
         checks++;
         if (clk_o !== 1'b1 || clk_div_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL %s_hi clk_o=%b ack=%b exp clk_o=1 ack=0", nm, clk_o, clk_div_ack_o);
         end
         @(negedge clk_i);
         #2;
         checks++;
         if (clk_o !== 1'b0) begin
            failures++;
            $display("FAIL %s_lo clk_o=%b exp=0", nm, clk_o);
         end
      end
   endtask

   task automatic test_reset();
      rstn_i = 1'b0;
      test_mode_i = 1'b0;
      clk_div_i = '0;
      clk_div_valid_i = 1'b0;
      @(posedge clk_i);
      #2;
      checks++;
      if (clk_o !== 1'b0 || clk_div_ack_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_hi clk_o=%b ack=%b exp 0 0", clk_o, clk_div_ack_o);
      end
      @(negedge clk_i);
      #2;
      checks++;
      if (clk_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_lo clk_o=%b exp=0", clk_o);
      end
      rstn_i = 1'b1;
      track_check("reset_bypass", 3);
   endtask

   task automatic test_div4();
      int c;
      logic [63:0] b;
      do_req(8'd4, 20, c);
      checks++;
      if (c !== 2) begin
         failures++;
         $display("FAIL div4_ack_latency got=%0d exp=2", c);
      end
      capture(8, b);
      checks++;
      if (b[15:0] !== 16'h0F0F) begin
         failures++;
         $display("FAIL div4_wave got=%h exp=0f0f", b[15:0]);
      end
   endtask

   task automatic test_div5();
      int c;
      logic [63:0] b;
      logic [19:0] e;
`ifdef PRVP_CLK_DIV_ODD50_EN
      e = 20'h07C1F;
`else
      e = 20'h03C0F;
`endif
      do_req(8'd5, 20, c);
      capture(10, b);
      checks++;
      if (b[19:0] !== e) begin
         failures++;
         $display("FAIL div5_wave got=%h exp=%h", b[19:0], e);
      end
   endtask

   task automatic test_pend_wrap();
      int c;
      logic [63:0] b;
      logic [11:0] e;
`ifdef PRVP_CLK_DIV_ODD50_EN
      e = 12'h1C7;
`else
      e = 12'h0C3;
`endif
      do_req(8'd6, 20, c);
      @(posedge clk_i);
      #1;
      do_req(8'd3, 20, c);
      checks++;
      if (c !== 5) begin
         failures++;
         $display("FAIL pend_wrap_latency got=%0d exp=5", c);
      end
      capture(6, b);
      checks++;
      if (b[11:0] !== e) begin
         failures++;
         $display("FAIL div3_wave got=%h exp=%h", b[11:0], e);
      end
   endtask

   task automatic test_test_mode();
      int c;
      logic [63:0] b;
      do_req(8'd4, 20, c);
      test_mode_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k != 0) @(posedge clk_i);
         #1;
         checks++;
         if (clk_o !== 1'b1) begin
            failures++;
            $display("FAIL test_mode_hi k=%0d clk_o=%b exp=1", k, clk_o);
         end
         @(negedge clk_i);
         #2;
         checks++;
         if (clk_o !== 1'b0) begin
            failures++;
            $display("FAIL test_mode_lo k=%0d clk_o=%b exp=0", k, clk_o);
         end
      end
      test_mode_i = 1'b0;
      @(posedge clk_i);
      #1;
      capture(4, b);
      checks++;
      if (b[7:0] !== 8'h0F) begin
         failures++;
         $display("FAIL test_mode_resume got=%h exp=0f", b[7:0]);
      end
   endtask

   task automatic test_same_ratio();
      int c;
      do_req(8'd4, 20, c);
      checks++;
      if (c < 2 || c > 5) begin
         failures++;
         $display("FAIL same_ratio_latency got=%0d exp=2..5", c);
      end
      @(posedge clk_i);
      #1;
      checks++;
      if (clk_div_ack_o !== 1'b0) begin
         failures++;
         $display("FAIL ack_pulse_width ack=%b exp=0", clk_div_ack_o);
      end
   endtask

   task automatic test_back_to_back();
      int c;
      logic [63:0] b;
      do_req(8'd2, 20, c);
      do_req(8'd2, 20, c);
      checks++;
      if (c !== 4) begin
         failures++;
         $display("FAIL back_to_back_latency got=%0d exp=4", c);
      end
      capture(4, b);
      checks++;
      if (b[7:0] !== 8'h33) begin
         failures++;
         $display("FAIL div2_wave got=%h exp=33", b[7:0]);
      end
   endtask

   task automatic test_max();
      int c;
      int ones;
      int e;
`ifdef PRVP_CLK_DIV_ODD50_EN
      e = 128;
`else
      e = 127;
`endif
      do_req(8'd255, 600, c);
      #1;
      ones = int'(clk_o);
      for (int k = 1; k < 255; k++) begin
         @(posedge clk_i);
         #2;
         ones += int'(clk_o);
      end
      checks++;
      if (ones !== e) begin
         failures++;
         $display("FAIL max_high_cycles got=%0d exp=%0d", ones, e);
      end
      @(posedge clk_i);
      #2;
      checks++;
      if (clk_o !== 1'b1) begin
         failures++;
         $display("FAIL max_wrap clk_o=%b exp=1", clk_o);
      end
   endtask

   task automatic test_run_to_bypass();
      int c;
      do_req(8'd1, 600, c);
      #1;
      checks++;
      if (clk_o !== 1'b1) begin
         failures++;
         $display("FAIL to_bypass_first clk_o=%b exp=1", clk_o);
      end
      @(negedge clk_i);
      #2;
      track_check("to_bypass", 3);
   endtask

   task automatic test_reset_pend();
      @(posedge clk_i);
      #1;
      clk_div_i = 8'd8;
      clk_div_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      checks++;
      if (clk_div_ack_o !== 1'b0) begin
         failures++;
         $display("FAIL pend_no_ack ack=%b exp=0", clk_div_ack_o);
      end
      rstn_i = 1'b0;
      clk_div_valid_i = 1'b0;
      #1;
      checks++;
      if (clk_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_pend_immediate clk_o=%b exp=0", clk_o);
      end
      for (int k = 0; k < 2; k++) begin
         @(posedge clk_i);
         #2;
         checks++;
         if (clk_o !== 1'b0 || clk_div_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_pend_hold clk_o=%b ack=%b exp 0 0", clk_o, clk_div_ack_o);
         end
      end
      @(negedge clk_i);
      #2;
      rstn_i = 1'b1;
      track_check("reset_pend_release", 4);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_div4();
      test_div5();
      test_pend_wrap();
      test_test_mode();
      test_same_ratio();
      test_back_to_back();
      test_max();
      test_run_to_bypass();
      test_reset_pend();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
